// File: rtl/gfx_pixel_arbiter_pkg.sv
// Shared types and width helpers for the gfx pixel-port arbiter and its round-robin picker.
package gfx_pixel_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Index width for n sources; a single source still needs one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_bits(input int max_beats);
    return (max_beats > 0) ? $clog2(max_beats + 1) : 1;
  endfunction

endpackage

// File: rtl/gfx_pixel_arbiter_if.sv
// Producer side (packed per-source slices) and framebuffer-writer side of the shared pixel port.
interface gfx_pixel_arbiter_if #(
  parameter int NUM_SRC    = 2,
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 9,
  parameter int PIXEL_BITS = 12
);

  logic [NUM_SRC-1:0]            src_pvalid;
  logic [NUM_SRC-1:0]            src_pready;
  logic [NUM_SRC-1:0]            src_last;
  logic [NUM_SRC*X_BITS-1:0]     src_x;
  logic [NUM_SRC*Y_BITS-1:0]     src_y;
  logic [NUM_SRC*PIXEL_BITS-1:0] src_color;

  logic [X_BITS-1:0]             gfx_x;
  logic [Y_BITS-1:0]             gfx_y;
  logic [PIXEL_BITS-1:0]         gfx_color;
  logic                          gfx_pvalid;
  logic                          gfx_pready;
  logic                          gfx_last;

  // Producers plus the downstream writer, seen from outside the arbiter.
  modport master (
    output src_pvalid, src_last, src_x, src_y, src_color, gfx_pready,
    input  src_pready, gfx_x, gfx_y, gfx_color, gfx_pvalid, gfx_last
  );

  modport slave (
    input  src_pvalid, src_last, src_x, src_y, src_color, gfx_pready,
    output src_pready, gfx_x, gfx_y, gfx_color, gfx_pvalid, gfx_last
  );

endinterface

// File: rtl/gfx_pixel_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NUM_SRC.
module gfx_rr_pick
  import gfx_pixel_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int IDX_W   = idx_bits(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  int w_best;
  int w_dist;

  // Smallest rotational distance from ptr wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_best  = NUM_SRC;
    w_dist  = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_dist = i - int'(i_ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + NUM_SRC;
      end
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/gfx_pixel_arbiter.sv
// Round-robin, burst-locked sharing of the framebuffer pixel-write port between NUM_SRC producers.
module gfx_pixel_arbiter
  import gfx_pixel_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int PIXEL_BITS = 12,
  parameter int MAX_BEATS  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  gfx_pixel_arbiter_if.slave             bus,
  output logic [idx_bits(NUM_SRC)-1:0]   grant,
  output logic                           busy
);

  localparam int GRANT_W = idx_bits(NUM_SRC);
  localparam int X_BITS  = $clog2(FB_WIDTH);
  localparam int Y_BITS  = $clog2(FB_HEIGHT);
  localparam int CNT_W   = cnt_bits(MAX_BEATS);
  localparam logic [CNT_W-1:0] BEAT_LIM = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [GRANT_W-1:0] r_grant;
  logic [GRANT_W-1:0] w_grant_nxt;
  logic [GRANT_W-1:0] r_rr_ptr;
  logic [GRANT_W-1:0] w_rr_nxt;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   w_beat_nxt;

  logic               w_found;
  logic [GRANT_W-1:0] w_pick;
  logic               w_sel_last;
  logic               w_forced;
  logic               w_beat;
  logic               w_release;

  gfx_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (GRANT_W)
  ) u_pick (
    .i_req   (bus.src_pvalid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // Output mux: only the granted source sees gfx_pready; nothing is driven outside GRANT.
  always_comb begin
    bus.src_pready = '0;
    bus.gfx_pvalid = 1'b0;
    bus.gfx_x      = '0;
    bus.gfx_y      = '0;
    bus.gfx_color  = '0;
    w_sel_last     = 1'b0;
    if (r_state == ST_GRANT) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (GRANT_W'(i) == r_grant) begin
          bus.gfx_pvalid    = bus.src_pvalid[i];
          bus.gfx_x         = bus.src_x[i*X_BITS +: X_BITS];
          bus.gfx_y         = bus.src_y[i*Y_BITS +: Y_BITS];
          bus.gfx_color     = bus.src_color[i*PIXEL_BITS +: PIXEL_BITS];
          bus.src_pready[i] = bus.gfx_pready;
          w_sel_last        = bus.src_last[i];
        end
      end
    end
  end

  assign w_forced     = (MAX_BEATS != 0) && (r_beat_cnt == BEAT_LIM);
  assign w_beat       = bus.gfx_pvalid && bus.gfx_pready;
  assign w_release    = w_beat && (w_sel_last || w_forced);
  assign bus.gfx_last = bus.gfx_pvalid && (w_sel_last || w_forced);

  assign grant = r_grant;
  assign busy  = (r_state == ST_GRANT);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_beat_nxt  = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_pick;
          w_beat_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = (r_grant == GRANT_W'(NUM_SRC - 1)) ? '0 : r_grant + 1'b1;
          w_beat_nxt  = '0;
        end else if (w_beat) begin
          w_beat_nxt  = r_beat_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

endmodule

// File: tb/tb_gfx_pixel_arbiter.sv
// Scoreboard bench: dut0 (3 sources, unlimited bursts) and dut1 (3 sources, MAX_BEATS=4).
module tb_gfx_pixel_arbiter;

  localparam int NS = 3;
  localparam int XB = 10;
  localparam int YB = 9;
  localparam int PB = 12;
  localparam int GW = 2;

  typedef struct packed {
    logic [GW-1:0] g;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic [PB-1:0] c;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  initial forever #5 clk = ~clk;

  gfx_pixel_arbiter_if #(.NUM_SRC(NS), .X_BITS(XB), .Y_BITS(YB), .PIXEL_BITS(PB)) b0 ();
  gfx_pixel_arbiter_if #(.NUM_SRC(NS), .X_BITS(XB), .Y_BITS(YB), .PIXEL_BITS(PB)) b1 ();
  logic [GW-1:0] g0, g1;
  logic          busy0, busy1;

  gfx_pixel_arbiter #(.NUM_SRC(NS), .FB_WIDTH(640), .FB_HEIGHT(480), .PIXEL_BITS(PB), .MAX_BEATS(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0), .grant(g0), .busy(busy0));
  gfx_pixel_arbiter #(.NUM_SRC(NS), .FB_WIDTH(640), .FB_HEIGHT(480), .PIXEL_BITS(PB), .MAX_BEATS(4)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .grant(g1), .busy(busy1));

  logic        sel;
  logic        en;
  int          pr_mode;
  int          scen;
  int          n_b [NS];
  int          bi [NS];
  int          pause_at [NS];
  int          pause_cnt [NS];
  logic [15:0] lastm [NS];
  beat_t       exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          beat_no = 0;
  int          beat_cyc [64];

  logic          m_pv, m_pr, m_last, m_busy;
  logic [GW-1:0] m_g;
  logic [XB-1:0] m_x;
  logic [YB-1:0] m_y;
  logic [PB-1:0] m_c;
  logic [NS-1:0] m_srdy;

  assign m_pv   = sel ? b1.gfx_pvalid : b0.gfx_pvalid;
  assign m_pr   = sel ? b1.gfx_pready : b0.gfx_pready;
  assign m_last = sel ? b1.gfx_last   : b0.gfx_last;
  assign m_busy = sel ? busy1         : busy0;
  assign m_g    = sel ? g1            : g0;
  assign m_x    = sel ? b1.gfx_x      : b0.gfx_x;
  assign m_y    = sel ? b1.gfx_y      : b0.gfx_y;
  assign m_c    = sel ? b1.gfx_color  : b0.gfx_color;
  assign m_srdy = sel ? b1.src_pready : b0.src_pready;

  function automatic logic [XB-1:0] mk_x(input int sc, input int s, input int k);
    return XB'(sc * 100 + s * 16 + k);
  endfunction
  function automatic logic [YB-1:0] mk_y(input int sc, input int s, input int k);
    return YB'(sc * 20 + s * 5 + k + 1);
  endfunction
  function automatic logic [PB-1:0] mk_c(input int sc, input int s, input int k);
    return PB'(256 * (s + 1) + sc * 16 + k);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_burst(input int s, input int k0, input int k1, input logic lastf);
    beat_t e;
    for (int k = k0; k <= k1; k++) begin
      e = {GW'(s), mk_x(scen, s, k), mk_y(scen, s, k), mk_c(scen, s, k), (k == k1) ? lastf : 1'b0};
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_all();
    for (int s = 0; s < NS; s++) begin
      n_b[s] = 0; bi[s] = 0; lastm[s] = '0; pause_at[s] = -1; pause_cnt[s] = 0;
    end
  endtask

  task automatic load(input int s, input int n, input logic [15:0] lm);
    n_b[s] = n; bi[s] = 0; lastm[s] = lm;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_busy && bi[0] >= n_b[0] && bi[1] >= n_b[1] && bi[2] >= n_b[2]) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 64'(done), 64'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Producer model: present beat bi[s] of each source, advance on a sampled handshake.
  initial begin
    logic [NS-1:0]    pv, hs, ls;
    logic [NS*XB-1:0] xs;
    logic [NS*YB-1:0] ys;
    logic [NS*PB-1:0] cs;
    logic             tog, gp;
    int               k;
    pv = '0; tog = 1'b0;
    b0.src_pvalid = '0; b0.src_last = '0; b0.src_x = '0; b0.src_y = '0; b0.src_color = '0; b0.gfx_pready = 1'b0;
    b1.src_pvalid = '0; b1.src_last = '0; b1.src_x = '0; b1.src_y = '0; b1.src_color = '0; b1.gfx_pready = 1'b0;
    forever begin
      @(negedge clk);
      hs = pv & (sel ? b1.src_pready : b0.src_pready);
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) begin
        if (hs[s]) bi[s]++;
        pv[s] = 1'b0;
        if (en) begin
          if (bi[s] == pause_at[s] && pause_cnt[s] > 0) pause_cnt[s]--;
          else pv[s] = (bi[s] < n_b[s]);
        end
        k = (bi[s] < n_b[s]) ? bi[s] : 0;
        xs[s*XB +: XB] = mk_x(scen, s, k);
        ys[s*YB +: YB] = mk_y(scen, s, k);
        cs[s*PB +: PB] = mk_c(scen, s, k);
        ls[s] = lastm[s][k[3:0]];
      end
      tog = ~tog;
      gp = (pr_mode == 0) ? 1'b1 : (pr_mode == 1) ? tog : 1'b0;
      b0.src_pvalid = sel ? '0 : pv;
      b1.src_pvalid = sel ? pv : '0;
      b0.src_x = xs; b0.src_y = ys; b0.src_color = cs; b0.src_last = ls; b0.gfx_pready = gp;
      b1.src_x = xs; b1.src_y = ys; b1.src_color = cs; b1.src_last = ls; b1.gfx_pready = gp;
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on every accepted beat.
  initial begin
    beat_t       cur, prev, e;
    logic        stall, lastbeat;
    logic [NS-1:0] exp_rdy;
    stall = 1'b0; lastbeat = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0; lastbeat = 1'b0;
      end else begin
        cur = {m_g, m_x, m_y, m_c, m_last};
        if (lastbeat) chk("idle_after_last", 64'(m_busy), 64'd0);
        lastbeat = 1'b0;
        exp_rdy = '0;
        if (m_busy) exp_rdy[m_g] = m_pr;
        chk("pready_excl", 64'(m_srdy), 64'(exp_rdy));
        if (!m_busy) chk("idle_quiet", 64'({m_pv, m_x, m_y, m_c, m_last}), 64'd0);
        if (stall && m_pv) chk("hold", 64'(cur), 64'(prev));
        if (m_pv && m_pr) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat actual=%0h required=none t=%0t", cur, $time);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 64'(cur), 64'(e));
          end
          if (beat_no < 64) beat_cyc[beat_no] = cyc + 1;
          beat_no++;
          lastbeat = m_last;
        end
        stall = m_pv && !m_pr;
        prev = cur;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, start, ok;
    sel = 1'b0; en = 1'b0; pr_mode = 0; scen = 0;
    clear_all();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_grant", 64'(g0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_pvalid", 64'(b0.gfx_pvalid), 64'd0);
    chk("rst_data", 64'({b0.gfx_x, b0.gfx_y, b0.gfx_color, b0.gfx_last}), 64'd0);

    // Single source, 4-beat burst: request seen one edge after pvalid, then beats back to back.
    scen = 1; clear_all(); load(0, 4, 16'h0008);
    push_burst(0, 0, 3, 1'b1);
    base = beat_no; start = cyc; en = 1'b1;
    wait_done("s1_done", 100);
    chk("s1_first_beat", 64'(beat_cyc[base]), 64'(start + 3));
    chk("s1_last_beat", 64'(beat_cyc[base + 3]), 64'(start + 6));

    // rr_ptr is 1 now, so source 1 leads the alternation.
    scen = 2; clear_all(); load(0, 6, 16'h0024); load(1, 6, 16'h0024);
    push_burst(1, 0, 2, 1'b1); push_burst(0, 0, 2, 1'b1);
    push_burst(1, 3, 5, 1'b1); push_burst(0, 3, 5, 1'b1);
    wait_done("s2_done", 100);

    // Source 1 pauses 5 cycles after its first beat while source 2 waits.
    scen = 3; clear_all(); load(1, 4, 16'h0008); load(2, 2, 16'h0002);
    pause_at[1] = 1; pause_cnt[1] = 5;
    push_burst(1, 0, 3, 1'b1); push_burst(2, 0, 1, 1'b1);
    base = beat_no;
    wait_done("s3_done", 100);
    chk("s3_pause_gap", 64'(beat_cyc[base + 1] - beat_cyc[base]), 64'd6);

    // Leave rr_ptr at 2, then stall a burst from source 2 and reset it mid-grant.
    scen = 4; clear_all(); load(1, 1, 16'h0001);
    push_burst(1, 0, 0, 1'b1);
    wait_done("s4a_done", 50);
    clear_all(); pr_mode = 2; load(2, 8, 16'h0080);
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (busy0) begin ok = 1; break; end
    end
    chk("s4_granted", 64'(ok), 64'd1);
    chk("s4_pre_grant", 64'(g0), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("s4_rst_grant", 64'(g0), 64'd0);
    chk("s4_rst_busy", 64'(busy0), 64'd0);
    chk("s4_rst_pvalid", 64'(b0.gfx_pvalid), 64'd0);
    chk("s4_rst_data", 64'({b0.gfx_x, b0.gfx_y, b0.gfx_color}), 64'd0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    scen = 5; clear_all(); pr_mode = 0; load(0, 2, 16'h0002); load(2, 2, 16'h0002);
    push_burst(0, 0, 1, 1'b1); push_burst(2, 0, 1, 1'b1);
    en = 1'b1;
    wait_done("s5_done", 100);

    // dut1: toggling pready, source 0 never sends last, so every 4th handshake is a forced release.
    @(negedge clk);
    sel = 1'b1;
    scen = 6; clear_all(); pr_mode = 1; load(0, 8, 16'h0000); load(1, 2, 16'h0002);
    push_burst(0, 0, 3, 1'b1); push_burst(1, 0, 1, 1'b1); push_burst(0, 4, 7, 1'b1);
    wait_done("s6_done", 200);

    en = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
